btb_2way: RTL

//  Parametrised 2-way set-associative branch target buffer with valid bits, LRU replacement and per-entry

---
 rtl/btb_pkg.sv | 28 ++
 rtl/btb_way.sv | 63 ++++++
 rtl/btb_2way.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way branch target buffer.
// Counter helpers are only referenced when BTB_HYST_EN is defined.
package btb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CTR_INIT = 2'b10;

  function automatic int unsigned sets_of(input int unsigned idx_w);
    return 32'd1 << idx_w;
  endfunction

  function automatic int unsigned step_of(input int unsigned align);
    return 32'd1 << align;
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: valid/tag/target (and ctr when BTB_HYST_EN) arrays,
// two async read ports (fetch lookup, resolve update) and one write port.
module btb_way
  import btb_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = 6,
  parameter int TGT_W = 14
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [TGT_W-1:0] lk_target,
`ifdef BTB_HYST_EN
  output logic [1:0]       lk_ctr,
  output logic [TGT_W-1:0] up_target,
  output logic [1:0]       up_ctr,
  input  logic [1:0]       wr_ctr,
`endif
  input  logic [IDX_W-1:0] up_idx,
  output logic             up_valid,
  output logic [TAG_W-1:0] up_tag,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [TGT_W-1:0] wr_target
);

  localparam int SETS = sets_of(IDX_W);

  // No reset on the arrays: the top clears them with a zero-write sweep.
  logic             valid_q  [SETS];
  logic [TAG_W-1:0] tag_q    [SETS];
  logic [TGT_W-1:0] target_q [SETS];
`ifdef BTB_HYST_EN
  logic [1:0]       ctr_q    [SETS];
`endif

  always_ff @(posedge clk) begin
    if (we) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
`ifdef BTB_HYST_EN
      ctr_q[wr_idx]    <= wr_ctr;
`endif
    end
  end

  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign up_valid  = valid_q[up_idx];
  assign up_tag    = tag_q[up_idx];
`ifdef BTB_HYST_EN
  assign lk_ctr    = ctr_q[lk_idx];
  assign up_target = target_q[up_idx];
  assign up_ctr    = ctr_q[up_idx];
`endif

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB with LRU replacement and an INIT clear sweep.
// BTB_HYST_EN adds 2-bit saturating direction counters per entry.
module btb_2way
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int IDX_W = 8,
  parameter int ALIGN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  output logic            ready,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic            taken_pred,
  output logic [PC_W-1:0] npc_pred,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int TAG_W = PC_W - IDX_W - ALIGN;
  localparam int TGT_W = PC_W - ALIGN;
  localparam int SETS  = sets_of(IDX_W);
  localparam logic [PC_W-1:0] STEP = PC_W'(step_of(ALIGN));

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             init;
  logic             live_upd;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (flush) begin
      state_d = ST_INIT;
      sweep_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_d = sweep_q + IDX_W'(1);
          if (&sweep_q) state_d = ST_RUN;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign init     = (state_q == ST_INIT);
  assign ready    = (state_q == ST_RUN) && !rst;
  // A flush or reset in the same cycle wins over a resolving branch.
  assign live_upd = ready && !flush && upd_valid;

  // Per-way read/write signals
  logic             way_lk_valid  [2];
  logic [TAG_W-1:0] way_lk_tag    [2];
  logic [TGT_W-1:0] way_lk_target [2];
  logic             way_up_valid  [2];
  logic [TAG_W-1:0] way_up_tag    [2];
`ifdef BTB_HYST_EN
  logic [1:0]       way_lk_ctr    [2];
  logic [TGT_W-1:0] way_up_target [2];
  logic [1:0]       way_up_ctr    [2];
  logic [1:0]       wr_ctr;
`endif

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [1:0]       lk_match, up_match, upd_we;
  logic             lk_sel, up_sel, up_hit, victim;
  logic             wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [TGT_W-1:0] wr_target;
  logic             lru_q [SETS];
  logic             lru_rd, lru_we, lru_wdata;

  assign lk_idx = lookup_pc[ALIGN +: IDX_W];
  assign lk_tag = lookup_pc[PC_W-1 -: TAG_W];
  assign up_idx = upd_pc[ALIGN +: IDX_W];
  assign up_tag = upd_pc[PC_W-1 -: TAG_W];

  logic unused_low_bits;
  assign unused_low_bits = ^{upd_pc[ALIGN-1:0], upd_target[ALIGN-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      btb_way #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W),
        .TGT_W(TGT_W)
      ) u_way (
        .clk       (clk),
        .lk_idx    (lk_idx),
        .lk_valid  (way_lk_valid[gi]),
        .lk_tag    (way_lk_tag[gi]),
        .lk_target (way_lk_target[gi]),
`ifdef BTB_HYST_EN
        .lk_ctr    (way_lk_ctr[gi]),
        .up_target (way_up_target[gi]),
        .up_ctr    (way_up_ctr[gi]),
        .wr_ctr    (init ? 2'b00 : wr_ctr),
`endif
        .up_idx    (up_idx),
        .up_valid  (way_up_valid[gi]),
        .up_tag    (way_up_tag[gi]),
        .we        (init | upd_we[gi]),
        .wr_idx    (init ? sweep_q : up_idx),
        .wr_valid  (init ? 1'b0 : wr_valid),
        .wr_tag    (init ? '0 : wr_tag),
        .wr_target (init ? '0 : wr_target)
      );

      assign lk_match[gi] = ready && way_lk_valid[gi] && (way_lk_tag[gi] == lk_tag);
      assign up_match[gi] = way_up_valid[gi] && (way_up_tag[gi] == up_tag);
    end
  endgenerate

  // Lookup: way0 wins when both ways match.
  assign hit    = |lk_match;
  assign lk_sel = !lk_match[0];
`ifdef BTB_HYST_EN
  assign taken_pred = hit && way_lk_ctr[lk_sel][1];
`else
  assign taken_pred = hit;
`endif
  assign npc_pred = taken_pred ? (PC_W'(way_lk_target[lk_sel]) << ALIGN)
                               : lookup_pc + STEP;

  assign lru_rd = lru_q[up_idx];
  assign up_hit = |up_match;
  assign up_sel = !up_match[0];
  assign victim = !way_up_valid[0] ? 1'b0 : (!way_up_valid[1] ? 1'b1 : lru_rd);

  always_comb begin
    upd_we    = 2'b00;
    wr_valid  = 1'b1;
    wr_tag    = up_tag;
    wr_target = upd_target[PC_W-1:ALIGN];
    lru_we    = 1'b0;
    lru_wdata = 1'b0;
`ifdef BTB_HYST_EN
    wr_ctr    = CTR_INIT;
`endif
    if (live_upd) begin
      if (up_hit) begin
        upd_we[up_sel] = 1'b1;
        lru_we         = 1'b1;
        lru_wdata      = !up_sel;
        if (upd_taken) begin
`ifdef BTB_HYST_EN
          wr_ctr = ctr_inc(way_up_ctr[up_sel]);
`endif
        end else begin
`ifdef BTB_HYST_EN
          wr_target = way_up_target[up_sel];
          wr_ctr    = ctr_dec(way_up_ctr[up_sel]);
`else
          // Drop the entry and mark its way LRU so it is refilled first.
          wr_valid  = 1'b0;
          lru_wdata = up_sel;
`endif
        end
      end else if (upd_taken) begin
        upd_we[victim] = 1'b1;
        lru_we         = 1'b1;
        lru_wdata      = !victim;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      lru_q[sweep_q] <= 1'b0;
    end else if (lru_we) begin
      lru_q[up_idx] <= lru_wdata;
    end
  end

endmodule
